conv_sched_ctrl: RTL and testbench
==================================

Name: conv_sched_ctrl

Overview:
- Sequencer that sits between the feature-map/weight BRAMs and the convolution block.
- After a start pulse it runs one pass per (output channel, input channel) pair, IN_FM_CH*OUT_FM_CH passes in total.
- Each pass: load the kernel weights, pulse the conv block's go, stream the feature map, then wait for every result before moving on.
- Reports completion with a one-cycle done pulse.

Parameters:
- KERNEL_SIZE, 3, kernel edge length (K); K*K weights per pass.
- FM_SIZE, 8, feature-map edge length; FM_SIZE^2 pixels per pass.
- PADDING, 0, padding; used only to derive OUT_SIZE.
- STRIDE, 1, stride; used only to derive OUT_SIZE.
- IN_FM_CH, 1, number of input channels.
- OUT_FM_CH, 1, number of output channels.
- FM_W, 30, feature-map word width.
- W_W, 18, weight word width.
- OUT_SIZE (localparam), ((FM_SIZE-K+2*PADDING)/STRIDE)+1; the conv block produces OUT_SIZE^2 results per pass.

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_go  in  1  start pulse; honoured only in IDLE.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse when the last pass completes.
- o_w_rd  out  1  weight BRAM read enable.
- o_w_addr  out  clog2(OUT_FM_CH*IN_FM_CH*K*K)  weight read address.
- i_w_data  in  W_W  weight read data; 1-cycle BRAM read latency.
- o_fm_rd  out  1  feature-map BRAM read enable.
- o_fm_addr  out  clog2(IN_FM_CH*FM_SIZE^2)  feature-map read address.
- i_fm_data  in  FM_W  feature-map read data; 1-cycle BRAM read latency.
- o_conv_go  out  1  one-cycle start pulse to the conv block.
- o_conv_weight  out  K*K*W_W  packed kernel; weight k sits at bits [k*W_W +: W_W].
- o_conv_fm_data  out  FM_W  pixel to the conv block.
- o_conv_fm_valid  out  1  o_conv_fm_data is valid this cycle.
- i_conv_en  in  1  conv block result-valid strobe.
- o_in_ch  out  clog2(IN_FM_CH)+1  current input-channel index.
- o_out_ch  out  clog2(OUT_FM_CH)+1  current output-channel index.

Behaviour:
- Reset: every output and internal counter clears to 0 immediately; state returns to IDLE; o_conv_weight clears to 0. Reset mid-pass abandons the pass with no done pulse.
- States: IDLE -> W_LOAD -> GO -> FM_STREAM -> DRAIN -> (next pass: W_LOAD | DONE) -> IDLE.
- IDLE:
  - i_go=1: clear in_ch, out_ch and all counters, go to W_LOAD.
  - i_go in any other state is ignored.
- W_LOAD:
  - o_w_rd high for K*K consecutive cycles; o_w_addr = (out_ch*IN_FM_CH+in_ch)*K*K + k, k=0..K*K-1.
  - The data word returned 1 cycle after read k is written into slot k.
  - Exit to GO the cycle after the last word is captured, so W_LOAD lasts K*K+1 cycles.
  - o_conv_weight holds stable from GO until the next W_LOAD.
- GO: o_conv_go=1 for exactly one cycle, then FM_STREAM.
- FM_STREAM:
  - o_fm_rd high for FM_SIZE^2 consecutive cycles; o_fm_addr = in_ch*FM_SIZE^2 + p, p=0..FM_SIZE^2-1 (raster order).
  - o_conv_fm_valid is o_fm_rd delayed 1 cycle; o_conv_fm_data = i_fm_data in that cycle.
  - Go to DRAIN after the last read issues.
- Result counting:
  - The result counter increments on each i_conv_en from GO through DRAIN, so results arriving during streaming are counted.
  - i_conv_en in IDLE, W_LOAD or DONE is ignored.
- DRAIN:
  - Wait until result count = OUT_SIZE^2. If the count is already reached on entry, leave DRAIN on the next cycle.
  - On exit, clear the result counter.
  - If in_ch < IN_FM_CH-1: in_ch+1.
  - Else: in_ch wraps to 0 and out_ch+1.
  - If out_ch has wrapped past OUT_FM_CH-1: go to DONE, else W_LOAD.
- DONE: o_done=1 for one cycle, then IDLE. o_in_ch and o_out_ch read 0 in IDLE.
- The result counter saturates at OUT_SIZE^2; surplus strobes are dropped.
- All address arithmetic is unsigned, zero-extended to the address width.

Optional Feature:
- Macro: SCHED_CYCLE_CNT_EN.
- Defined:
  - Adds output o_cycle_cnt (32-bit).
  - Clears on accepted i_go, increments every cycle while o_busy, freezes in IDLE.
  - Saturates at 2^32-1.
  - Reset value 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Test configuration: K=3, FM_SIZE=5, PADDING=0, STRIDE=1, IN_FM_CH=2, OUT_FM_CH=2 (OUT_SIZE=3).
- Full run:
  - Stimulus: i_go pulse; conv model returns 9 i_conv_en strobes per go.
  - Expected: exactly 4 o_conv_go pulses; weight base addresses 0, 9, 18, 27; FM base addresses 0, 25, 0, 25; one o_done; o_busy falls the same cycle o_done falls.
- Weight packing:
  - Stimulus: weight BRAM word at address a = a+1.
  - Expected: first-pass o_conv_weight slot k = k+1 for k=0..8, stable through FM_STREAM.
- FM timing:
  - Stimulus: FM word at address a = 100+a.
  - Expected: 25 consecutive o_conv_fm_valid cycles, each 1 cycle after o_fm_rd; data 100..124 on the first pass.
- Early/late results:
  - Stimulus: 4 strobes during FM_STREAM and 5 during DRAIN; separately, 12 strobes in one pass.
  - Expected: DRAIN exits after the 9th strobe in both cases; extra strobes cause no extra pass or error.
- Go/reset robustness:
  - Stimulus: i_go while busy.
  - Expected: ignored, address sequence unchanged.
  - Stimulus: i_rst asserted mid-FM_STREAM, then released, then i_go.
  - Expected: outputs 0 immediately, no o_done; the next i_go restarts from weight address 0.
- SCHED_CYCLE_CNT_EN:
  - Stimulus: full run with zero-latency conv strobes.
  - Expected: o_cycle_cnt equals the number of o_busy cycles and holds that value in IDLE.

Source files
------------

// File: rtl/conv_sched_ctrl.sv
// conv_sched_ctrl: sequences weight loads, conv start pulses and feature-map streaming per channel pair; SCHED_CYCLE_CNT_EN adds o_cycle_cnt
module conv_sched_ctrl #(
   parameter int KERNEL_SIZE = 3,
   parameter int FM_SIZE = 8,
   parameter int PADDING = 0,
   parameter int STRIDE = 1,
   parameter int IN_FM_CH = 1,
   parameter int OUT_FM_CH = 1,
   parameter int FM_W = 30,
   parameter int W_W = 18,
   localparam int K = KERNEL_SIZE,
   localparam int KK = K*K,
   localparam int FS2 = FM_SIZE*FM_SIZE,
   localparam int OUT_SIZE = ((FM_SIZE-K+2*PADDING)/STRIDE)+1,
   localparam int OS2 = OUT_SIZE*OUT_SIZE,
   localparam int WA = (OUT_FM_CH*IN_FM_CH*KK > 1) ? $clog2(OUT_FM_CH*IN_FM_CH*KK) : 1,
   localparam int FA = (IN_FM_CH*FS2 > 1) ? $clog2(IN_FM_CH*FS2) : 1,
   localparam int IW = $clog2(IN_FM_CH)+1,
   localparam int OW = $clog2(OUT_FM_CH)+1,
   localparam int CW = $clog2(((KK > FS2) ? KK : FS2)+1),
   localparam int RW = $clog2(OS2+1)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_go,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_w_rd,
   output logic [WA-1:0]      o_w_addr,
   input  logic [W_W-1:0]     i_w_data,
   output logic               o_fm_rd,
   output logic [FA-1:0]      o_fm_addr,
   input  logic [FM_W-1:0]    i_fm_data,
   output logic               o_conv_go,
   output logic [KK*W_W-1:0]  o_conv_weight,
   output logic [FM_W-1:0]    o_conv_fm_data,
   output logic               o_conv_fm_valid,
   input  logic               i_conv_en,
   output logic [IW-1:0]      o_in_ch,
   output logic [OW-1:0]      o_out_ch
`ifdef SCHED_CYCLE_CNT_EN
   ,
   output logic [31:0]        o_cycle_cnt
`endif
);
   typedef enum logic [2:0] {IDLE, W_LOAD, GO, FM_STREAM, DRAIN, DONE} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic [RW-1:0] res_cnt;
   logic last_in, last_out, res_full, res_win;
   logic [IW-1:0] nxt_in;
   logic [OW-1:0] nxt_out;

   function automatic logic [WA-1:0] w_base(input logic [OW-1:0] oc, input logic [IW-1:0] ic);
      return WA'((int'(oc)*IN_FM_CH + int'(ic))*KK);
   endfunction

   assign last_in = o_in_ch == IW'(IN_FM_CH-1);
   assign last_out = o_out_ch == OW'(OUT_FM_CH-1);
   assign nxt_in = last_in ? '0 : o_in_ch + IW'(1);
   assign nxt_out = last_in ? o_out_ch + OW'(1) : o_out_ch;
   assign res_full = res_cnt == RW'(OS2);
   assign res_win = state == GO || state == FM_STREAM || state == DRAIN;
   assign o_conv_fm_data = o_conv_fm_valid ? i_fm_data : '0;

   // Pass sequencer: weight load, conv start, pixel stream, result drain, channel advance
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         state <= IDLE;
         cnt <= '0;
         o_busy <= 1'b0;
         o_done <= 1'b0;
         o_w_rd <= 1'b0;
         o_w_addr <= '0;
         o_fm_rd <= 1'b0;
         o_fm_addr <= '0;
         o_conv_go <= 1'b0;
         o_conv_weight <= '0;
         o_conv_fm_valid <= 1'b0;
         o_in_ch <= '0;
         o_out_ch <= '0;
      end else begin
         o_done <= 1'b0;
         o_conv_go <= 1'b0;
         o_conv_fm_valid <= o_fm_rd;
         case (state)
            IDLE: if (i_go) begin
               state <= W_LOAD;
               o_busy <= 1'b1;
               o_in_ch <= '0;
               o_out_ch <= '0;
               cnt <= '0;
               o_w_rd <= 1'b1;
               o_w_addr <= '0;
            end
            W_LOAD: begin
               if (cnt != '0) o_conv_weight[(int'(cnt)-1)*W_W +: W_W] <= i_w_data;
               o_w_rd <= cnt < CW'(KK-1);
               if (cnt < CW'(KK-1)) o_w_addr <= o_w_addr + WA'(1);
               cnt <= cnt + CW'(1);
               if (cnt == CW'(KK)) begin
                  state <= GO;
                  o_conv_go <= 1'b1;
                  cnt <= '0;
               end
            end
            GO: begin
               state <= FM_STREAM;
               o_fm_rd <= 1'b1;
               o_fm_addr <= FA'(int'(o_in_ch)*FS2);
            end
            FM_STREAM: begin
               cnt <= cnt + CW'(1);
               if (cnt == CW'(FS2-1)) begin
                  state <= DRAIN;
                  o_fm_rd <= 1'b0;
                  cnt <= '0;
               end else o_fm_addr <= o_fm_addr + FA'(1);
            end
            DRAIN: if (res_full) begin
               o_in_ch <= nxt_in;
               o_out_ch <= (last_in && last_out) ? '0 : nxt_out;
               if (last_in && last_out) begin
                  state <= DONE;
                  o_done <= 1'b1;
               end else begin
                  state <= W_LOAD;
                  o_w_rd <= 1'b1;
                  o_w_addr <= w_base(nxt_out, nxt_in);
               end
            end
            DONE: begin
               state <= IDLE;
               o_busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end

   // Result counter: counts strobes from GO through DRAIN, saturates, clears when a pass drains
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) res_cnt <= '0;
      else if (state == IDLE || (state == DRAIN && res_full)) res_cnt <= '0;
      else if (i_conv_en && res_win && !res_full) res_cnt <= res_cnt + RW'(1);

`ifdef SCHED_CYCLE_CNT_EN
   // Busy-cycle counter: restarts on an accepted go, saturates, holds its value in IDLE
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) o_cycle_cnt <= '0;
      else if (state == IDLE && i_go) o_cycle_cnt <= '0;
      else if (o_busy && o_cycle_cnt != '1) o_cycle_cnt <= o_cycle_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_conv_sched_ctrl.sv
// tb_conv_sched_ctrl: randomized self-checking bench for conv_sched_ctrl (K=3, FM 5x5, 2 in / 2 out channels)
module tb_conv_sched_ctrl;
   localparam int K = 3, FS = 5, IC = 2, OC = 2, FM_W = 30, W_W = 18;
   localparam int KK = K*K, FS2 = FS*FS, NP = IC*OC;
   logic clk = 1'b0, rst = 1'b1, go = 1'b0, conv_en = 1'b0;
   logic busy, done, w_rd, fm_rd, conv_go, fm_valid;
   logic [5:0] w_addr, fm_addr;
   logic [W_W-1:0] w_data = '0;
   logic [FM_W-1:0] fm_data = '0, conv_fm_data;
   logic [KK*W_W-1:0] conv_weight;
   logic [1:0] in_ch, out_ch;
`ifdef SCHED_CYCLE_CNT_EN
   logic [31:0] cycle_cnt;
`endif
   logic [W_W-1:0] wmem [NP*KK];
   logic [FM_W-1:0] fmem [IC*FS2];
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   // weight and feature-map BRAMs with one cycle of read latency
   always @(posedge clk) begin
      if (w_rd) w_data <= wmem[w_addr];
      if (fm_rd) fm_data <= fmem[fm_addr];
   end

   conv_sched_ctrl #(.KERNEL_SIZE(K), .FM_SIZE(FS), .PADDING(0), .STRIDE(1), .IN_FM_CH(IC),
                     .OUT_FM_CH(OC), .FM_W(FM_W), .W_W(W_W)) dut (
      .i_clk(clk), .i_rst(rst), .i_go(go), .o_busy(busy), .o_done(done),
      .o_w_rd(w_rd), .o_w_addr(w_addr), .i_w_data(w_data),
      .o_fm_rd(fm_rd), .o_fm_addr(fm_addr), .i_fm_data(fm_data),
      .o_conv_go(conv_go), .o_conv_weight(conv_weight), .o_conv_fm_data(conv_fm_data),
      .o_conv_fm_valid(fm_valid), .i_conv_en(conv_en), .o_in_ch(in_ch), .o_out_ch(out_ch)
`ifdef SCHED_CYCLE_CNT_EN
      , .o_cycle_cnt(cycle_cnt)
`endif
   );

   // mode 0: 9 strobes anywhere, 1: 4 while streaming + 5 later, 2: 12 strobes, 3: strobes right after go
   task automatic check_run(input int mode, input bit noise);
      bit [0:47] sch [NP];
      int e [NP];
      int nbusy, n, s9, o;
      logic [KK*W_W-1:0] ew;
      for (int j = 0; j < NP; j++) begin
         sch[j] = '0;
         if (mode == 3) for (int i = 0; i < 9; i++) sch[j][i] = 1'b1;
         else for (int i = 0; i < ((mode == 2) ? 12 : 9); i++) begin
            do o = (mode == 1) ? ((i < 4) ? int'($urandom_range(25, 1)) : int'($urandom_range(45, 26))) : int'($urandom_range(45, 0));
            while (sch[j][o]);
            sch[j][o] = 1'b1;
         end
         n = 0;
         s9 = 0;
         for (int i = 0; i < 48; i++) if (sch[j][i]) begin
            n++;
            if (n == 9) s9 = i;
         end
         e[j] = (s9 + 1 > FS2 + 1) ? s9 + 1 : FS2 + 1;
      end
      nbusy = 0;
      @(negedge clk);
      go = 1'b1;
      for (int j = 0; j < NP; j++) begin
         for (int k = 0; k < KK; k++) ew[k*W_W +: W_W] = wmem[j*KK+k];
         for (int c = 0; c <= KK; c++) begin
            @(negedge clk);
            go = noise ? 1'($urandom) : 1'b0;
            conv_en = noise ? 1'($urandom) : 1'b0;
            nbusy++;
            total++; if (w_rd !== (c < KK)) begin bad++; $display("FAIL w_rd pass=%0d c=%0d got=%b exp=%b", j, c, w_rd, c < KK); end
            if (c < KK) begin total++; if (w_addr !== 6'(j*KK+c)) begin bad++; $display("FAIL w_addr pass=%0d c=%0d got=%0d exp=%0d", j, c, w_addr, j*KK+c); end end
            total++; if ({busy, conv_go, done} !== 3'b100) begin bad++; $display("FAIL wload_flags pass=%0d c=%0d busy/go/done got=%b exp=100", j, c, {busy, conv_go, done}); end
         end
         @(negedge clk);
         nbusy++;
         conv_en = sch[j][0];
         go = noise ? 1'($urandom) : 1'b0;
         total++; if (conv_go !== 1'b1) begin bad++; $display("FAIL conv_go pass=%0d got=%b exp=1", j, conv_go); end
         total++; if ({out_ch, in_ch} !== {2'(j/IC), 2'(j%IC)}) begin bad++; $display("FAIL channel pass=%0d got=%0d/%0d exp=%0d/%0d", j, out_ch, in_ch, j/IC, j%IC); end
         total++; if (conv_weight !== ew) begin bad++; $display("FAIL weights_go pass=%0d got=%h exp=%h", j, conv_weight, ew); end
         for (int off = 1; off <= e[j]; off++) begin
            @(negedge clk);
            nbusy++;
            conv_en = sch[j][off];
            go = noise ? 1'($urandom) : 1'b0;
            total++; if ({conv_go, done, busy} !== 3'b001) begin bad++; $display("FAIL stream_flags pass=%0d off=%0d go/done/busy got=%b exp=001", j, off, {conv_go, done, busy}); end
            total++; if (fm_rd !== (off <= FS2)) begin bad++; $display("FAIL fm_rd pass=%0d off=%0d got=%b exp=%b", j, off, fm_rd, off <= FS2); end
            if (off <= FS2) begin total++; if (fm_addr !== 6'((j%IC)*FS2+off-1)) begin bad++; $display("FAIL fm_addr pass=%0d off=%0d got=%0d exp=%0d", j, off, fm_addr, (j%IC)*FS2+off-1); end end
            total++; if (fm_valid !== (off >= 2 && off <= FS2+1)) begin bad++; $display("FAIL fm_valid pass=%0d off=%0d got=%b", j, off, fm_valid); end
            if (off >= 2 && off <= FS2+1) begin total++; if (conv_fm_data !== fmem[(j%IC)*FS2+off-2]) begin bad++; $display("FAIL fm_data pass=%0d off=%0d got=%0d exp=%0d", j, off, conv_fm_data, fmem[(j%IC)*FS2+off-2]); end end
            total++; if (conv_weight !== ew) begin bad++; $display("FAIL weights_hold pass=%0d off=%0d got=%h exp=%h", j, off, conv_weight, ew); end
         end
      end
      @(negedge clk);
      nbusy++;
      go = 1'b0;
      conv_en = noise ? 1'($urandom) : 1'b0;
      total++; if ({done, busy} !== 2'b11) begin bad++; $display("FAIL done_pulse done/busy got=%b exp=11", {done, busy}); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         conv_en = 1'($urandom);
         total++; if ({done, busy, conv_go, w_rd, fm_rd} !== 5'b0) begin bad++; $display("FAIL idle_flags i=%0d got=%b exp=00000", i, {done, busy, conv_go, w_rd, fm_rd}); end
         total++; if ({in_ch, out_ch} !== 4'b0) begin bad++; $display("FAIL idle_channel i=%0d got=%b exp=0", i, {in_ch, out_ch}); end
`ifdef SCHED_CYCLE_CNT_EN
         total++; if (cycle_cnt !== 32'(nbusy)) begin bad++; $display("FAIL cycle_cnt i=%0d got=%0d exp=%0d", i, cycle_cnt, nbusy); end
`endif
      end
      conv_en = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      total++; if ({busy, done, w_rd, fm_rd, conv_go, fm_valid} !== 6'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0", {busy, done, w_rd, fm_rd, conv_go, fm_valid}); end
      total++; if ({w_addr, fm_addr, in_ch, out_ch} !== 16'b0) begin bad++; $display("FAIL reset_idx got=%h exp=0", {w_addr, fm_addr, in_ch, out_ch}); end
      total++; if ({conv_weight, conv_fm_data} !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", {conv_weight, conv_fm_data}); end
`ifdef SCHED_CYCLE_CNT_EN
      total++; if (cycle_cnt !== 32'd0) begin bad++; $display("FAIL reset_cycle_cnt got=%0d exp=0", cycle_cnt); end
`endif
      rst = 1'b0;
   endtask

   task automatic test_full_run;
      check_run(0, 1'b0);
   endtask

   task automatic test_early_late;
      check_run(1, 1'b0);
   endtask

   task automatic test_surplus;
      check_run(2, 1'b0);
   endtask

   task automatic test_go_busy;
      check_run(0, 1'b1);
   endtask

   task automatic test_zero_latency;
      check_run(3, 1'b0);
   endtask

   task automatic test_reset_mid;
      int n;
      n = $urandom_range(30, 14);
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      repeat (n - 1) @(negedge clk);
      total++; if (fm_rd !== 1'b1) begin bad++; $display("FAIL pre_reset_stream n=%0d got=%b exp=1", n, fm_rd); end
      rst = 1'b1;
      #1;
      total++; if ({busy, done, w_rd, fm_rd, conv_go, fm_valid} !== 6'b0) begin bad++; $display("FAIL midrst_flags got=%b exp=0", {busy, done, w_rd, fm_rd, conv_go, fm_valid}); end
      total++; if ({w_addr, fm_addr, in_ch, out_ch} !== 16'b0) begin bad++; $display("FAIL midrst_idx got=%h exp=0", {w_addr, fm_addr, in_ch, out_ch}); end
      total++; if ({conv_weight, conv_fm_data} !== '0) begin bad++; $display("FAIL midrst_data got=%h exp=0", {conv_weight, conv_fm_data}); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 2) rst = 1'b0;
         total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL midrst_hold i=%0d done/busy got=%b exp=00", i, {done, busy}); end
      end
      check_run(0, 1'b0);
   endtask

   task automatic test_random;
      for (int r = 0; r < 3; r++) begin
         foreach (wmem[a]) wmem[a] = W_W'($urandom);
         foreach (fmem[a]) fmem[a] = FM_W'($urandom);
         check_run($urandom_range(2, 0), 1'($urandom));
      end
   endtask

   initial begin
      foreach (wmem[a]) wmem[a] = W_W'(a + 1);
      foreach (fmem[a]) fmem[a] = FM_W'(100 + a);
      test_reset();
      test_full_run();
      test_early_late();
      test_surplus();
      test_go_busy();
      test_reset_mid();
      test_zero_latency();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
